// File: rtl/regfile_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader_pkg
// Description : Shared widths and dump FSM state encoding for the register
//               file debug read-out path.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_dump_reader_pkg;

   localparam int REG_IDX_W = 5;
   localparam int XLEN      = 32;
   localparam int NUM_REGS  = 32;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]      xlen_t;

   // Dump FSM state encoding, shared with the debug path
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/regfile_dump_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader_if
// Description : Register file debug read port plus the valid/ready dump
//               stream toward the debug/trace path.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_dump_reader_if;
   import regfile_dump_reader_pkg::*;

   reg_idx_t dbg_addr;
   xlen_t    dbg_rdata;
   logic     out_valid;
   logic     out_ready;
   xlen_t    out_data;
   reg_idx_t out_index;
   logic     out_last;

   // Dump engine side: drives the read address and the stream
   modport master (
      output dbg_addr,
      input  dbg_rdata,
      output out_valid,
      input  out_ready,
      output out_data,
      output out_index,
      output out_last
   );

   // Register file / consumer side
   modport slave (
      input  dbg_addr,
      output dbg_rdata,
      input  out_valid,
      output out_ready,
      input  out_data,
      input  out_index,
      input  out_last
   );

endinterface
`default_nettype wire

// File: rtl/regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : regfile_dump_reader
// Description : Walks the register file asynchronous read port from
//               FIRST_REG to LAST_REG, emitting one captured register per
//               valid/ready beat, then pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_dump_reader
   import regfile_dump_reader_pkg::*;
#(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              start,
   input  wire logic              abort,
   regfile_dump_reader_if.master  dump,
   output logic                   busy,
   output logic                   done
);

   localparam reg_idx_t FIRST_IDX = reg_idx_t'(FIRST_REG);
   localparam reg_idx_t LAST_IDX  = reg_idx_t'(LAST_REG);

   logic [1:0] r_state;
   reg_idx_t   r_idx;
   logic       r_out_valid;
   xlen_t      r_out_data;
   reg_idx_t   r_out_index;
   logic       r_out_last;

   // The read address comes straight from the index register so it never glitches
   assign dump.dbg_addr  = r_idx;
   assign dump.out_valid = r_out_valid;
   assign dump.out_data  = r_out_data;
   assign dump.out_index = r_out_index;
   assign dump.out_last  = r_out_last;

   assign busy = (r_state == ST_READ) || (r_state == ST_HOLD);
   assign done = (r_state == ST_DONE);

   // Dump sequencer and stream output register; abort wins over everything in READ/HOLD
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_idx       <= FIRST_IDX;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_index <= '0;
         r_out_last  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_idx <= FIRST_IDX;
               if (start && !abort) begin
                  r_state <= ST_READ;
               end
            end
            ST_READ: begin
               if (abort) begin
                  r_state <= ST_IDLE;
                  r_idx   <= FIRST_IDX;
               end else begin
                  // Capture whatever the read port shows before this edge
                  r_out_data  <= dump.dbg_rdata;
                  r_out_index <= r_idx;
                  r_out_last  <= (r_idx == LAST_IDX);
                  r_out_valid <= 1'b1;
                  r_state     <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (abort) begin
                  r_out_valid <= 1'b0;
                  r_state     <= ST_IDLE;
                  r_idx       <= FIRST_IDX;
               end else if (dump.out_ready) begin
                  r_out_valid <= 1'b0;
                  if (r_idx == LAST_IDX) begin
                     r_state <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + reg_idx_t'(1);
                     r_state <= ST_READ;
                  end
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
               r_idx   <= FIRST_IDX;
            end
            default: begin
               r_state <= ST_IDLE;
               r_idx   <= FIRST_IDX;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_dump_reader
// Description : Directed self-checking bench for regfile_dump_reader with a
//               full-range instance and a single-register instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_dump_reader;
   import regfile_dump_reader_pkg::*;

   logic clk = 1'b0;
   logic rst;
   logic start0, abort0, start1, abort1;
   logic busy0, done0, busy1, done1;

   logic [31:0] rf [32];
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_dump_reader_if if0 ();
   regfile_dump_reader_if if1 ();

   regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) u0 (
      .clk   (clk),
      .rst   (rst),
      .start (start0),
      .abort (abort0),
      .dump  (if0.master),
      .busy  (busy0),
      .done  (done0)
   );

   regfile_dump_reader #(.FIRST_REG(2), .LAST_REG(2)) u1 (
      .clk   (clk),
      .rst   (rst),
      .start (start1),
      .abort (abort1),
      .dump  (if1.master),
      .busy  (busy1),
      .done  (done1)
   );

   // Register file model: asynchronous read, write on the clock edge
   assign if0.dbg_rdata = rf[if0.dbg_addr];
   assign if1.dbg_rdata = rf[if1.dbg_addr];

   always @(posedge clk) begin
      if (wr_en) rf[wr_addr] <= wr_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Run until the full-range instance shows beat idx; ok=0 on timeout
   task automatic wait_beat(input int idx, output logic ok);
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (if0.out_valid && (32'(if0.out_index) == idx)) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Full dump on u0 with out_ready high, checking every beat
   task automatic run_dump(input logic hold_start, output int beats, output int dones,
                           output int done_cyc, output logic [31:0] cap5);
      int exp_idx;
      int post;
      exp_idx  = 0;
      beats    = 0;
      dones    = 0;
      done_cyc = -1;
      cap5     = 32'hx;
      post     = 0;
      start0   = 1'b1;
      tick();
      start0   = hold_start;
      for (int c = 1; c <= 100; c++) begin
         tick();
         if (if0.out_valid) begin
            chk("beat_index", 32'(if0.out_index), 32'(exp_idx));
            chk("beat_data", if0.out_data, (exp_idx < 32) ? rf[exp_idx] : 32'hx);
            chk("beat_last", 32'(if0.out_last), 32'(exp_idx == 31));
            if (exp_idx == 5) cap5 = if0.out_data;
            exp_idx++;
            beats++;
         end
         if (done0) begin
            dones++;
            done_cyc = c;
            start0   = 1'b0;
         end
         if (dones > 0) begin
            post++;
            if (post == 3) break;
         end
      end
      start0 = 1'b0;
      chk("busy_after_dump", 32'(busy0), 32'd0);
      chk("valid_after_dump", 32'(if0.out_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          beats, dones, done_cyc;
      logic [31:0] cap5;
      logic        ok;

      rst           = 1'b1;
      start0        = 1'b0;
      abort0        = 1'b0;
      start1        = 1'b0;
      abort1        = 1'b0;
      wr_en         = 1'b0;
      wr_addr       = '0;
      wr_data       = '0;
      if0.out_ready = 1'b1;
      if1.out_ready = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] <= 32'h0;
      rf[2] <= 32'h7fff_efe4;
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_dbg_addr", 32'(if0.dbg_addr), 32'd0);
      chk("rst_valid", 32'(if0.out_valid), 32'd0);
      chk("rst_data", if0.out_data, 32'd0);
      chk("rst_index", 32'(if0.out_index), 32'd0);
      chk("rst_last", 32'(if0.out_last), 32'd0);
      chk("rst_busy", 32'(busy0), 32'd0);
      chk("rst_done", 32'(done0), 32'd0);
      chk("rst_u1_dbg_addr", 32'(if1.dbg_addr), 32'd2);

      // Full dump of the default register file
      run_dump(1'b0, beats, dones, done_cyc, cap5);
      chk("full_beats", 32'(beats), 32'd32);
      chk("full_dones", 32'(dones), 32'd1);
      chk("full_done_cycle", 32'(done_cyc), 32'd64);

      // Backpressure on beat 2
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_beat(2, ok);
      chk("bp_reach_beat2", 32'(ok), 32'd1);
      if0.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_valid", 32'(if0.out_valid), 32'd1);
         chk("bp_data", if0.out_data, 32'h7fff_efe4);
         chk("bp_index", 32'(if0.out_index), 32'd2);
      end
      if0.out_ready = 1'b1;
      tick();
      chk("bp_gap_valid", 32'(if0.out_valid), 32'd0);
      tick();
      chk("bp_next_valid", 32'(if0.out_valid), 32'd1);
      chk("bp_next_index", 32'(if0.out_index), 32'd3);
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      chk("bp_abort_busy", 32'(busy0), 32'd0);

      // Abort during HOLD at index 10
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_beat(10, ok);
      chk("ab_reach_beat10", 32'(ok), 32'd1);
      if0.out_ready = 1'b0;
      abort0        = 1'b1;
      tick();
      abort0 = 1'b0;
      chk("ab_valid", 32'(if0.out_valid), 32'd0);
      chk("ab_busy", 32'(busy0), 32'd0);
      chk("ab_done", 32'(done0), 32'd0);
      chk("ab_dbg_addr", 32'(if0.dbg_addr), 32'd0);
      if0.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ab_no_done", 32'(done0), 32'd0);
         chk("ab_idle_valid", 32'(if0.out_valid), 32'd0);
      end
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("restart_busy", 32'(busy0), 32'd1);
      chk("restart_no_valid_yet", 32'(if0.out_valid), 32'd0);
      tick();
      chk("restart_valid", 32'(if0.out_valid), 32'd1);
      chk("restart_index", 32'(if0.out_index), 32'd0);
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;

      // Write to x5 on the edge that captures index 5
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      wait_beat(4, ok);
      chk("wc_reach_beat4", 32'(ok), 32'd1);
      tick();
      chk("wc_read_addr", 32'(if0.dbg_addr), 32'd5);
      wr_en   = 1'b1;
      wr_addr = 5'd5;
      wr_data = 32'hdead_beef;
      tick();
      wr_en = 1'b0;
      chk("wc_index", 32'(if0.out_index), 32'd5);
      chk("wc_old_data", if0.out_data, 32'h0);
      abort0 = 1'b1;
      tick();
      abort0 = 1'b0;
      run_dump(1'b0, beats, dones, done_cyc, cap5);
      chk("wc_rerun_x5", cap5, 32'hdead_beef);
      chk("wc_rerun_beats", 32'(beats), 32'd32);

      // start held high through a whole dump
      run_dump(1'b1, beats, dones, done_cyc, cap5);
      chk("hs_beats", 32'(beats), 32'd32);
      chk("hs_dones", 32'(dones), 32'd1);
      chk("hs_done_cycle", 32'(done_cyc), 32'd64);

      // Single-register instance
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk("one_busy", 32'(busy1), 32'd1);
      tick();
      chk("one_valid", 32'(if1.out_valid), 32'd1);
      chk("one_index", 32'(if1.out_index), 32'd2);
      chk("one_data", if1.out_data, 32'h7fff_efe4);
      chk("one_last", 32'(if1.out_last), 32'd1);
      tick();
      chk("one_done", 32'(done1), 32'd1);
      chk("one_valid_gone", 32'(if1.out_valid), 32'd0);
      tick();
      chk("one_done_pulse", 32'(done1), 32'd0);
      chk("one_idle_busy", 32'(busy1), 32'd0);

      // Asynchronous reset while holding a beat
      if1.out_ready = 1'b0;
      start1        = 1'b1;
      tick();
      start1 = 1'b0;
      tick();
      chk("rh_valid_before", 32'(if1.out_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rh_valid", 32'(if1.out_valid), 32'd0);
      chk("rh_data", if1.out_data, 32'd0);
      chk("rh_index", 32'(if1.out_index), 32'd0);
      chk("rh_last", 32'(if1.out_last), 32'd0);
      chk("rh_busy", 32'(busy1), 32'd0);
      chk("rh_done", 32'(done1), 32'd0);
      chk("rh_dbg_addr", 32'(if1.dbg_addr), 32'd2);
      tick();
      rst           = 1'b0;
      if1.out_ready = 1'b1;
      tick();
      chk("rh_stays_idle", 32'(busy1), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
